// File: rtl/retire_ctrl.sv
// In-order commit controller: acks ROB heads, updates the arch map, sequences stores, flushes and halts.
// Optional performance counters are built only when RETIRE_PERF_CNT_EN is defined.
module retire_ctrl #(
    parameter int WAYS      = 2,
    parameter int PREG_BITS = 6,
    parameter int AR_BITS   = 5,
    parameter int XLEN      = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WAYS-1:0]           head_valid,
    input  logic [WAYS-1:0]           head_halt,
    input  logic [WAYS-1:0]           head_wr_mem,
    input  logic [WAYS-1:0]           head_pse,
    input  logic [WAYS*XLEN-1:0]      head_target_pc,
    input  logic [WAYS*PREG_BITS-1:0] head_t_idx,
    input  logic [WAYS*PREG_BITS-1:0] head_told_idx,
    input  logic [WAYS*AR_BITS-1:0]   head_ar_idx,
    input  logic [WAYS*XLEN-1:0]      head_st_addr,
    input  logic [WAYS*XLEN-1:0]      head_st_data,
    output logic [WAYS-1:0]           retire_ack,
    output logic [WAYS-1:0]           amap_we,
    output logic [WAYS*AR_BITS-1:0]   amap_ar,
    output logic [WAYS*PREG_BITS-1:0] amap_t,
    output logic [WAYS-1:0]           fl_free,
    output logic [WAYS*PREG_BITS-1:0] fl_idx,
    output logic                      mem_wr_req,
    output logic [XLEN-1:0]           mem_wr_addr,
    output logic [XLEN-1:0]           mem_wr_data,
    input  logic                      mem_wr_ack,
    output logic                      flush,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      halted,
    output logic [63:0]               perf_retired,
    output logic [63:0]               perf_stall_cyc
);

    typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH, HALTED} state_t;

    state_t            state;
    logic [XLEN-1:0]   st_addr_q;
    logic [XLEN-1:0]   st_data_q;
    logic [XLEN-1:0]   pc_q;
    logic              st_pse_q;

    logic              blocked;
    logic              ev_store;
    logic              ev_pse;
    logic              ev_halt;
    logic [XLEN-1:0]   nxt_addr;
    logic [XLEN-1:0]   nxt_data;
    logic [XLEN-1:0]   nxt_pc;
    logic              nxt_st_pse;

    // A store is checked before pse so that a store carrying pse still reaches memory first.
    always_comb begin
        retire_ack = '0;
        blocked    = 1'b0;
        ev_store   = 1'b0;
        ev_pse     = 1'b0;
        ev_halt    = 1'b0;
        nxt_addr   = '0;
        nxt_data   = '0;
        nxt_pc     = '0;
        nxt_st_pse = 1'b0;
        case (state)
            RUN: begin
                for (int i = 0; i < WAYS; i++) begin
                    if (!blocked) begin
                        if (!head_valid[i]) begin
                            blocked = 1'b1;
                        end else if (head_halt[i]) begin
                            retire_ack[i] = 1'b1;
                            blocked       = 1'b1;
                            ev_halt       = 1'b1;
                        end else if (head_wr_mem[i]) begin
                            blocked    = 1'b1;
                            ev_store   = 1'b1;
                            nxt_addr   = head_st_addr[i*XLEN +: XLEN];
                            nxt_data   = head_st_data[i*XLEN +: XLEN];
                            nxt_pc     = head_target_pc[i*XLEN +: XLEN];
                            nxt_st_pse = head_pse[i];
                        end else if (head_pse[i]) begin
                            retire_ack[i] = 1'b1;
                            blocked       = 1'b1;
                            ev_pse        = 1'b1;
                            nxt_pc        = head_target_pc[i*XLEN +: XLEN];
                        end else begin
                            retire_ack[i] = 1'b1;
                        end
                    end
                end
            end
            STORE_WAIT: retire_ack[0] = mem_wr_ack;
            default: ;
        endcase
        if (reset) begin
            retire_ack = '0;
        end
    end

    always_comb begin
        amap_we = '0;
        amap_ar = '0;
        amap_t  = '0;
        fl_free = '0;
        fl_idx  = '0;
        for (int i = 0; i < WAYS; i++) begin
            amap_we[i] = retire_ack[i] && (head_ar_idx[i*AR_BITS +: AR_BITS] != '0);
            fl_free[i] = amap_we[i];
            if (amap_we[i]) begin
                amap_ar[i*AR_BITS +: AR_BITS]     = head_ar_idx[i*AR_BITS +: AR_BITS];
                amap_t[i*PREG_BITS +: PREG_BITS]  = head_t_idx[i*PREG_BITS +: PREG_BITS];
                fl_idx[i*PREG_BITS +: PREG_BITS]  = head_told_idx[i*PREG_BITS +: PREG_BITS];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            st_pse_q   <= 1'b0;
            pc_q       <= '0;
            mem_wr_req <= 1'b0;
            flush      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (ev_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (ev_store) begin
                        state      <= STORE_WAIT;
                        mem_wr_req <= 1'b1;
                        st_addr_q  <= nxt_addr;
                        st_data_q  <= nxt_data;
                        st_pse_q   <= nxt_st_pse;
                        if (nxt_st_pse) begin
                            pc_q <= nxt_pc;
                        end
                    end else if (ev_pse) begin
                        state <= FLUSH;
                        flush <= 1'b1;
                        pc_q  <= nxt_pc;
                    end
                end
                STORE_WAIT: begin
                    if (mem_wr_ack) begin
                        mem_wr_req <= 1'b0;
                        if (st_pse_q) begin
                            state <= FLUSH;
                            flush <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH:  state <= RUN;
                HALTED: state <= HALTED;
            endcase
        end
    end

    assign mem_wr_addr = st_addr_q;
    assign mem_wr_data = st_data_q;
    assign redirect_pc = pc_q;

`ifdef RETIRE_PERF_CNT_EN
    logic [63:0] retired_q;
    logic [63:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_q + 64'($countones(retire_ack));
            if (state == STORE_WAIT || state == FLUSH) begin
                stall_q <= stall_q + 64'd1;
            end
        end
    end

    assign perf_retired   = retired_q;
    assign perf_stall_cyc = stall_q;
`else
    assign perf_retired   = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboard bench for retire_ctrl: a program queue models the ROB, and every instruction
// contributes its architectural events (store, retire, flush) in program order.
module tb_retire_ctrl;

    localparam int EV_RET = 0;
    localparam int EV_ST  = 1;
    localparam int EV_FL  = 2;

    typedef struct {
        bit          halt;
        bit          st;
        bit          pse;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  t;
        logic [5:0]  told;
        logic [4:0]  ar;
    } ent_t;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  t;
        logic [5:0]  told;
        logic [4:0]  ar;
        bit          halt;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  head_valid = '0, head_halt = '0, head_wr_mem = '0, head_pse = '0;
    logic [63:0] head_target_pc = '0, head_st_addr = '0, head_st_data = '0;
    logic [11:0] head_t_idx = '0, head_told_idx = '0;
    logic [9:0]  head_ar_idx = '0;
    logic [1:0]  retire_ack, amap_we, fl_free;
    logic [9:0]  amap_ar;
    logic [11:0] amap_t, fl_idx;
    logic        mem_wr_req, mem_wr_ack = 1'b0, flush, halted;
    logic [31:0] mem_wr_addr, mem_wr_data, redirect_pc;
    logic [63:0] perf_retired, perf_stall_cyc;

    ent_t prog[$];
    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   mon_ack_cnt = 0;
    bit   rst_req = 1'b1;
    bit   full_valid = 1'b0;
    bit   spur_en = 1'b0;
    int   fixed_delay = -1;
    int   ack_delay = 0;
    int   ack_cnt = 0;

    retire_ctrl dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_halt(head_halt), .head_wr_mem(head_wr_mem),
        .head_pse(head_pse), .head_target_pc(head_target_pc), .head_t_idx(head_t_idx),
        .head_told_idx(head_told_idx), .head_ar_idx(head_ar_idx),
        .head_st_addr(head_st_addr), .head_st_data(head_st_data),
        .retire_ack(retire_ack), .amap_we(amap_we), .amap_ar(amap_ar), .amap_t(amap_t),
        .fl_free(fl_free), .fl_idx(fl_idx),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .flush(flush), .redirect_pc(redirect_pc), .halted(halted),
        .perf_retired(perf_retired), .perf_stall_cyc(perf_stall_cyc)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic get_ev(input int kind, input string nm, output ev_t v, output bit ok);
        total++;
        ok = 1'b0;
        v  = '{default: 0};
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s actual=event required=no_event", nm);
        end else begin
            v = exp_q.pop_front();
            if (v.kind != kind) begin
                bad++;
                $display("[TB] FAIL %s actual_kind=%0d required_kind=%0d", nm, kind, v.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    function automatic ent_t mk(bit h, bit st, bit p, logic [31:0] pc, logic [31:0] addr,
                                logic [31:0] data, logic [4:0] ar, logic [5:0] t, logic [5:0] told);
        ent_t e;
        e.halt = h; e.st = st; e.pse = p; e.pc = pc; e.addr = addr; e.data = data;
        e.ar = ar; e.t = t; e.told = told;
        return e;
    endfunction

    function automatic ent_t rand_ent(bit allow_halt);
        int r;
        r = $urandom_range(0, 99);
        return mk(allow_halt, !allow_halt && r < 25, !allow_halt && r >= 25 && r < 40,
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  6'($urandom), 6'($urandom));
    endfunction

    // The expected architectural effect of an instruction, independent of when it retires.
    task automatic issue(input ent_t e);
        ev_t v;
        v = '{default: 0};
        prog.push_back(e);
        if (e.st && !e.halt) begin
            v.kind = EV_ST; v.a = e.addr; v.b = e.data;
            exp_q.push_back(v);
        end
        v.kind = EV_RET; v.ar = e.ar; v.t = e.t; v.told = e.told; v.halt = e.halt;
        exp_q.push_back(v);
        if (e.pse && !e.halt) begin
            v.kind = EV_FL; v.a = e.pc;
            exp_q.push_back(v);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        for (int k = 0; k < mon_ack_cnt; k++) begin
            if (prog.size() > 0) void'(prog.pop_front());
        end
        mon_ack_cnt = 0;
        reset = rst_req;
        for (int i = 0; i < 2; i++) begin
            ent_t e;
            bit   v;
            if (i < prog.size()) begin
                e = prog[i];
                v = full_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
                e = rand_ent(1'b0);
                v = 1'b0;
            end
            head_valid[i] = v;         head_halt[i] = e.halt;
            head_wr_mem[i] = e.st;     head_pse[i] = e.pse;
            head_target_pc[i*32 +: 32] = e.pc;
            head_st_addr[i*32 +: 32]   = e.addr;
            head_st_data[i*32 +: 32]   = e.data;
            head_t_idx[i*6 +: 6]       = e.t;
            head_told_idx[i*6 +: 6]    = e.told;
            head_ar_idx[i*5 +: 5]      = e.ar;
        end
        if (mem_wr_req) begin
            if (ack_cnt >= ack_delay) begin
                mem_wr_ack = 1'b1;
                ack_cnt    = 0;
            end else begin
                mem_wr_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            ack_cnt    = 0;
            ack_delay  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            mem_wr_ack = spur_en && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        applyStimulus();
        prog.delete();
        exp_q.delete();
        applyStimulus();
        #3;
        checkOutput("rst_ack", 64'(retire_ack), 64'd0);
        checkOutput("rst_amap_we", 64'(amap_we), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_wr_req), 64'd0);
        checkOutput("rst_flush", 64'(flush), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_redirect", 64'(redirect_pc), 64'd0);
        checkOutput("rst_perf", perf_retired | perf_stall_cyc, 64'd0);
        rst_req = 1'b0;
    endtask

    // Monitor: turns each cycle's outputs into architectural events and matches them in order.
    initial begin : monitor
        ev_t         v;
        bit          ok, prev_req, halt_next, exp_halted;
        logic [31:0] cur_a, cur_d;
        logic [63:0] perf_model;
        prev_req = 0; halt_next = 0; exp_halted = 0; perf_model = '0; cur_a = '0; cur_d = '0;
        forever begin
            @(negedge clock);
            #3;
            mon_ack_cnt = $countones(retire_ack);
            if (reset) begin
                prev_req = 0; halt_next = 0; exp_halted = 0; perf_model = '0;
            end else begin
                if (halt_next) exp_halted = 1'b1;
                halt_next = 1'b0;
                checkOutput("halted", 64'(halted), 64'(exp_halted));
                if (exp_halted) checkOutput("halt_no_ack", 64'(retire_ack), 64'd0);
                checkOutput("ack_prefix", 64'(retire_ack == 2'b10), 64'd0);
                if (mem_wr_req && !prev_req) begin
                    get_ev(EV_ST, "store_evt", v, ok);
                    cur_a = v.a;
                    cur_d = v.b;
                    if (ok) begin
                        checkOutput("store_addr", 64'(mem_wr_addr), 64'(v.a));
                        checkOutput("store_data", 64'(mem_wr_data), 64'(v.b));
                    end
                end else if (mem_wr_req) begin
                    checkOutput("store_hold", {mem_wr_addr, mem_wr_data}, {cur_a, cur_d});
                end
                prev_req = mem_wr_req;
                if (flush) begin
                    get_ev(EV_FL, "flush_evt", v, ok);
                    if (ok) checkOutput("redirect_pc", 64'(redirect_pc), 64'(v.a));
                end
                for (int i = 0; i < 2; i++) begin
                    if (retire_ack[i]) begin
                        get_ev(EV_RET, "retire_evt", v, ok);
                        if (ok) begin
                            checkOutput("ret_we", 64'(amap_we[i]), 64'(v.ar != 0));
                            checkOutput("ret_free", 64'(fl_free[i]), 64'(v.ar != 0));
                            if (v.ar != 0) begin
                                checkOutput("ret_ar", 64'(amap_ar[i*5 +: 5]), 64'(v.ar));
                                checkOutput("ret_t", 64'(amap_t[i*6 +: 6]), 64'(v.t));
                                checkOutput("ret_told", 64'(fl_idx[i*6 +: 6]), 64'(v.told));
                            end
                            if (v.halt) halt_next = 1'b1;
                        end
                    end else begin
                        checkOutput("idle_we_free", 64'({amap_we[i], fl_free[i]}), 64'd0);
                    end
                end
`ifdef RETIRE_PERF_CNT_EN
                checkOutput("perf_retired", perf_retired, perf_model);
                perf_model = perf_model + 64'($countones(retire_ack));
`else
                checkOutput("perf_tied", perf_retired | perf_stall_cyc, 64'd0);
`endif
            end
        end
    end

    initial begin : stimulus
        bit found;
        int hold;
        do_reset();

        full_valid = 1'b1;
        issue(mk(0, 0, 0, 0, 0, 0, 5'd3, 6'd20, 6'd10));
        issue(mk(0, 0, 0, 0, 0, 0, 5'd4, 6'd21, 6'd11));
        applyStimulus(); #3;
        checkOutput("alu_ack", 64'(retire_ack), 64'd3);
        checkOutput("alu_amap_we", 64'(amap_we), 64'd3);
        checkOutput("alu_fl_idx", 64'(fl_idx), 64'({6'd11, 6'd10}));
        applyStimulus(); #3;
`ifdef RETIRE_PERF_CNT_EN
        checkOutput("alu_perf", perf_retired, 64'd2);
`endif

        fixed_delay = 3;
        issue(mk(0, 0, 0, 0, 0, 0, 5'd5, 6'd22, 6'd12));
        issue(mk(0, 1, 0, 0, 32'h100, 32'hdeadbeef, 5'd0, 6'd0, 6'd0));
        applyStimulus(); #3;
        checkOutput("st_first_ack", 64'(retire_ack), 64'd1);
        found = 0;
        hold  = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            applyStimulus(); #3;
            if (mem_wr_ack) begin
                found = 1;
                checkOutput("st_ack_cycle", 64'(retire_ack), 64'd1);
                checkOutput("st_hold_cycles", 64'(hold), 64'd3);
            end else if (mem_wr_req) begin
                hold++;
                if (hold == 1) checkOutput("st_req_addr", 64'(mem_wr_addr), 64'h100);
            end
        end
        checkOutput("st_ack_seen", 64'(found), 64'd1);
        applyStimulus(); #3;
        checkOutput("st_req_drop", 64'(mem_wr_req), 64'd0);
        fixed_delay = -1;

        issue(mk(0, 0, 1, 32'h2000, 0, 0, 5'd6, 6'd23, 6'd13));
        issue(mk(0, 0, 0, 0, 0, 0, 5'd7, 6'd24, 6'd14));
        applyStimulus(); #3;
        checkOutput("pse_ack", 64'(retire_ack), 64'd1);
        applyStimulus(); #3;
        checkOutput("pse_flush", 64'(flush), 64'd1);
        checkOutput("pse_redirect", 64'(redirect_pc), 64'h2000);
        checkOutput("pse_flush_ack", 64'(retire_ack), 64'd0);
        applyStimulus(); #3;
        checkOutput("pse_flush_once", 64'(flush), 64'd0);
        checkOutput("pse_resume_ack", 64'(retire_ack), 64'd1);

        issue(mk(0, 0, 0, 0, 0, 0, 5'd0, 6'd25, 6'd15));
        issue(mk(1, 0, 0, 0, 0, 0, 5'd8, 6'd26, 6'd16));
        applyStimulus(); #3;
        checkOutput("halt_ack", 64'(retire_ack), 64'd3);
        checkOutput("ar0_we", 64'(amap_we[0]), 64'd0);
        checkOutput("ar0_free", 64'(fl_free[0]), 64'd0);
        issue(mk(0, 0, 0, 0, 0, 0, 5'd9, 6'd27, 6'd17));
        issue(mk(0, 0, 0, 0, 0, 0, 5'd10, 6'd28, 6'd18));
        applyStimulus(); #3;
        checkOutput("halt_set", 64'(halted), 64'd1);
        repeat (3) applyStimulus();
        #3;
        checkOutput("halt_stays", 64'({halted, retire_ack}), 64'h4);

        do_reset();
        fixed_delay = 20;
        issue(mk(0, 1, 0, 0, 32'h40, 32'h1234, 5'd1, 6'd1, 6'd2));
        for (int c = 0; c < 5 && !mem_wr_req; c++) begin
            applyStimulus(); #3;
        end
        checkOutput("rst_st_req_seen", 64'(mem_wr_req), 64'd1);
        do_reset();
        fixed_delay = -1;

        full_valid = 1'b0;
        spur_en    = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int n, limit, cyc;
            bit early;
            do_reset();
            n = $urandom_range(3, 14);
            for (int k = 0; k < n; k++) issue(rand_ent(k == n - 1 && $urandom_range(0, 3) == 0));
            early = ($urandom_range(0, 4) == 0);
            limit = early ? int'($urandom_range(2, 12)) : 600;
            cyc   = 0;
            while (exp_q.size() > 0 && cyc < limit) begin
                applyStimulus();
                cyc++;
            end
            if (!early) begin
                repeat (4) applyStimulus();
                #4;
                checkOutput("drain", 64'(exp_q.size()), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
